// File: rtl/alloc_client.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alloc_client                                                 |
// | Description : Single-command requester for the linked-memory allocator.    |
// |               Upstream takes ALLOC/FREE/REALLOC/READ/WRITE/FREE_LIST/NOP   |
// |               commands. Downstream drives the allocator strobes and        |
// |               operands and samples its registered results. FREE_LIST      |
// |               walks a linked list and returns each cell to the heap.       |
// | Ports       : i_clk, i_rst_n (async active-low)                            |
// |               i_cmd_valid/o_cmd_ready/i_cmd_op/i_cmd_arg0/i_cmd_arg1       |
// |               o_rsp_valid/o_rsp_data/o_rsp_err  (one-cycle response pulse) |
// |               o_alloc/o_free/o_wr/o_rd + operands o_data/o_faddr/o_wdata/  |
// |               o_waddr/o_raddr; results i_addr/i_rdata/i_err; o_err sticky  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alloc_client #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8,
  parameter int MEM_MAX = 1 << ADDR_SZ
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [2:0]         i_cmd_op,
  input  logic [DATA_SZ-1:0] i_cmd_arg0,
  input  logic [DATA_SZ-1:0] i_cmd_arg1,
  output logic               o_rsp_valid,
  output logic [DATA_SZ-1:0] o_rsp_data,
  output logic               o_rsp_err,
  output logic               o_alloc,
  output logic               o_free,
  output logic               o_wr,
  output logic               o_rd,
  output logic [DATA_SZ-1:0] o_data,
  output logic [DATA_SZ-1:0] o_faddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic [DATA_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_addr,
  input  logic [DATA_SZ-1:0] i_rdata,
  input  logic               i_err,
  output logic               o_err
);

  // Tagged word constants (encoding fixed for a 16-bit word)
  localparam logic [DATA_SZ-1:0] C_UNDEF   = 16'h0000;
  localparam logic [DATA_SZ-1:0] C_NIL     = 16'h0001;
  localparam logic [DATA_SZ-1:0] C_UNIT    = 16'h0004;
  localparam logic [DATA_SZ-1:0] C_ZERO    = 16'h8000;
  localparam int                 C_MUT_BIT = 14;
  localparam logic [ADDR_SZ:0]   C_CNT_MAX = MEM_MAX[ADDR_SZ:0];

  localparam logic [2:0] C_OP_NOP     = 3'd0;
  localparam logic [2:0] C_OP_ALLOC   = 3'd1;
  localparam logic [2:0] C_OP_FREE    = 3'd2;
  localparam logic [2:0] C_OP_REALLOC = 3'd3;
  localparam logic [2:0] C_OP_READ    = 3'd4;
  localparam logic [2:0] C_OP_WRITE   = 3'd5;
  localparam logic [2:0] C_OP_FLIST   = 3'd6;
  localparam logic [2:0] C_OP_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_ISSUE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_W_RD    = 3'd4,
    S_W_CAP   = 3'd5,
    S_W_FREE  = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t             r_state;
  logic [2:0]         r_op;
  logic [DATA_SZ-1:0] r_ptr;   // cell currently being walked
  logic [DATA_SZ-1:0] r_next;  // link read from r_ptr before it is freed
  logic [ADDR_SZ:0]   r_cnt;   // cells freed so far in this walk

  logic [ADDR_SZ:0]   w_cnt_inc;
  logic [DATA_SZ-1:0] w_walk_rsp;
  logic               w_walk_stop;
  logic               w_in_flight;

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_walk_rsp = C_ZERO | {{(DATA_SZ-ADDR_SZ-1){1'b0}}, w_cnt_inc};
  // Stop on end of list, on a link without the mutable tag, or on a cycle.
  assign w_walk_stop = (r_next == C_NIL) || !r_next[C_MUT_BIT] || (w_cnt_inc == C_CNT_MAX);
  // A command accepted this very cycle counts as in flight.
  assign w_in_flight = (r_state == S_ISSUE) || (r_state == S_CAPTURE) ||
                       (r_state == S_W_RD) || (r_state == S_W_CAP) ||
                       (r_state == S_W_FREE) || ((r_state == S_IDLE) && i_cmd_valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_INIT;
      r_op        <= C_OP_NOP;
      r_ptr       <= C_UNDEF;
      r_next      <= C_UNDEF;
      r_cnt       <= '0;
      o_cmd_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= C_UNDEF;
      o_rsp_err   <= 1'b0;
      o_alloc     <= 1'b0;
      o_free      <= 1'b0;
      o_wr        <= 1'b0;
      o_rd        <= 1'b0;
      o_data      <= C_UNDEF;
      o_faddr     <= C_UNDEF;
      o_wdata     <= C_UNDEF;
      o_waddr     <= C_UNDEF;
      o_raddr     <= C_UNDEF;
      o_err       <= 1'b0;
    end else begin
      // Pulses default low every cycle
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_alloc     <= 1'b0;
      o_free      <= 1'b0;
      o_wr        <= 1'b0;
      o_rd        <= 1'b0;

      if ((r_state != S_INIT) && (r_state != S_ERROR) && i_err) begin
        r_state     <= S_ERROR;
        o_err       <= 1'b1;
        o_cmd_ready <= 1'b0;
        if (w_in_flight) begin
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b1;
          o_rsp_data  <= C_UNDEF;
        end
      end else begin
        case (r_state)
          S_INIT: begin
            // Allocator powers up halted; wait for it to come out of error.
            if (!i_err) begin
              r_state     <= S_IDLE;
              o_cmd_ready <= 1'b1;
            end
          end
          S_IDLE: begin
            if (i_cmd_valid) begin
              o_cmd_ready <= 1'b0;
              r_op        <= i_cmd_op;
              r_state     <= S_ISSUE;
              case (i_cmd_op)
                C_OP_ALLOC: begin
                  o_alloc <= 1'b1;
                  o_data  <= i_cmd_arg0;
                end
                C_OP_FREE: begin
                  o_free  <= 1'b1;
                  o_faddr <= i_cmd_arg0;
                end
                C_OP_REALLOC: begin
                  o_alloc <= 1'b1;
                  o_data  <= i_cmd_arg0;
                  o_free  <= 1'b1;
                  o_faddr <= i_cmd_arg1;
                end
                C_OP_READ: begin
                  o_rd    <= 1'b1;
                  o_raddr <= i_cmd_arg0;
                end
                C_OP_WRITE: begin
                  o_wr    <= 1'b1;
                  o_waddr <= i_cmd_arg0;
                  o_wdata <= i_cmd_arg1;
                end
                C_OP_FLIST: begin
                  // An empty list takes the plain ISSUE/CAPTURE path.
                  if (i_cmd_arg0 != C_NIL) begin
                    o_rd    <= 1'b1;
                    o_raddr <= i_cmd_arg0;
                    r_ptr   <= i_cmd_arg0;
                    r_cnt   <= '0;
                    r_state <= S_W_RD;
                  end
                end
                default: ;
              endcase
            end
          end
          S_ISSUE: begin
            r_state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            r_state     <= S_IDLE;
            o_cmd_ready <= 1'b1;
            o_rsp_valid <= 1'b1;
            case (r_op)
              C_OP_ALLOC, C_OP_REALLOC: o_rsp_data <= i_addr;
              C_OP_READ:                o_rsp_data <= i_rdata;
              C_OP_WRITE:               o_rsp_data <= C_UNIT;
              C_OP_FLIST:               o_rsp_data <= C_ZERO;
              C_OP_ILLEGAL: begin
                o_rsp_data <= C_UNDEF;
                o_rsp_err  <= 1'b1;
              end
              default:                  o_rsp_data <= C_UNDEF;
            endcase
          end
          S_W_RD: begin
            r_state <= S_W_CAP;
          end
          S_W_CAP: begin
            // Link captured before the free clobbers it.
            r_next  <= i_rdata;
            o_free  <= 1'b1;
            o_faddr <= r_ptr;
            r_state <= S_W_FREE;
          end
          S_W_FREE: begin
            r_cnt <= w_cnt_inc;
            if (w_walk_stop) begin
              r_state     <= S_IDLE;
              o_cmd_ready <= 1'b1;
              o_rsp_valid <= 1'b1;
              o_rsp_data  <= w_walk_rsp;
              o_rsp_err   <= (r_next != C_NIL);
            end else begin
              o_rd    <= 1'b1;
              o_raddr <= r_next;
              r_ptr   <= r_next;
              r_state <= S_W_RD;
            end
          end
          S_ERROR: begin
            o_cmd_ready <= 1'b0;
          end
          default: r_state <= S_ERROR;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alloc_client.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alloc_client                                              |
// | Description : Self-checking bench for alloc_client with a behavioural     |
// |               allocator (tagged addresses 16'h50xx, LIFO free stack,      |
// |               freed cells overwritten) and a response scoreboard.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alloc_client;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_arg0 = 16'h0;
  logic [15:0] cmd_arg1 = 16'h0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alloc, free, wr, rd;
  logic [15:0] data, faddr, wdata, waddr, raddr;
  logic [15:0] addr_res = 16'h0;
  logic [15:0] rdata_res = 16'h0;
  logic        alloc_err = 1'b1;
  logic        err;

  alloc_client dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_arg0(cmd_arg0), .i_cmd_arg1(cmd_arg1),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_alloc(alloc), .o_free(free), .o_wr(wr), .o_rd(rd),
    .o_data(data), .o_faddr(faddr), .o_wdata(wdata), .o_waddr(waddr), .o_raddr(raddr),
    .i_addr(addr_res), .i_rdata(rdata_res), .i_err(alloc_err), .o_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_alloc = 0, n_free = 0, n_rd = 0, n_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- allocator model ----------------
  logic [15:0] mem [256];
  logic [7:0]  fstk [256];
  int          fsz = 0;
  logic [7:0]  nfresh = 8'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      fsz       <= 0;
      nfresh    <= 8'd0;
      addr_res  <= 16'h0;
      rdata_res <= 16'h0;
    end else begin
      if (alloc) begin
        if (fsz > 0) begin
          addr_res          <= {8'h50, fstk[fsz-1]};
          mem[fstk[fsz-1]]  <= data;
        end else begin
          addr_res          <= 16'h5000 | {8'h00, nfresh};
          mem[nfresh]       <= data;
          nfresh            <= nfresh + 8'd1;
        end
      end
      if (free) begin
        mem[faddr[7:0]] <= 16'h0BAD;  // freeing clobbers the link
        if (alloc && fsz > 0) fstk[fsz-1] <= faddr[7:0];
        else begin
          fstk[fsz] <= faddr[7:0];
          fsz       <= fsz + 1;
        end
      end else if (alloc && fsz > 0) begin
        fsz <= fsz - 1;
      end
      if (rd) rdata_res <= mem[raddr[7:0]];
      if (wr) mem[waddr[7:0]] <= wdata;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] d;
    logic        e;
    int          c;
  } exp_t;
  exp_t sbq[$];
  exp_t ex;

  always @(negedge clk) begin
    if (alloc) n_alloc++;
    if (free)  n_free++;
    if (rd)    n_rd++;
    if (wr)    n_wr++;
    if (rst_n && rsp_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected cyc=%0d data=%h err=%b", cyc, rsp_data, rsp_err);
      end else begin
        ex = sbq.pop_front();
        if (rsp_data !== ex.d || rsp_err !== ex.e || cyc != ex.c) begin
          errors++;
          $display("FAIL rsp got data=%h err=%b cyc=%0d expected data=%h err=%b cyc=%0d",
                   rsp_data, rsp_err, cyc, ex.d, ex.e, ex.c);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  // Offers one command at a negedge once ready is seen; returns at the
  // negedge of the cycle after acceptance (where the strobes are visible).
  task automatic send(input logic [2:0] op, input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] ed, input logic ee, input int lat, output int t);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    t = cyc;
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL ready_timeout op=%0d ready=%b required=1", op, cmd_ready);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg0  = a0;
    cmd_arg1  = a1;
    sbq.push_back('{ed, ee, t + lat});
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_arg0  = 16'($urandom);
    cmd_arg1  = 16'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic err_lvl);
    @(negedge clk);
    alloc_err = err_lvl;
    rst_n = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int hi = 0;
    alloc_err = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, alloc, free, wr, rd, err,
         rsp_data, data, faddr, wdata, waddr, raddr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rsp=%b alloc=%b free=%b rd=%b wr=%b err=%b required all 0",
               cmd_ready, rsp_valid, alloc, free, rd, wr, err);
    end
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (cmd_ready) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL init_ready_while_err cycles_high=%0d required=0", hi);
    end
    alloc_err = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_ready_rise ready=%b required=1", cmd_ready);
    end
  endtask

  task automatic test_alloc();
    int t;
    send(3'd1, 16'h8005, 16'h0, 16'h5000, 1'b0, 3, t);
    checks++;
    if (alloc !== 1'b1 || data !== 16'h8005 || free !== 1'b0) begin
      errors++;
      $display("FAIL alloc_strobe alloc=%b data=%h free=%b required 1/8005/0", alloc, data, free);
    end
    drain();
    checks++;
    if (sbq.size() != 0 || n_alloc != 1) begin
      errors++;
      $display("FAIL alloc_drain pending=%0d alloc_pulses=%0d required 0/1", sbq.size(), n_alloc);
    end
  endtask

  task automatic test_write_read();
    int t;
    send(3'd5, 16'h5000, 16'h8007, 16'h0004, 1'b0, 3, t);
    checks++;
    if (wr !== 1'b1 || waddr !== 16'h5000 || wdata !== 16'h8007) begin
      errors++;
      $display("FAIL write_strobe wr=%b waddr=%h wdata=%h required 1/5000/8007", wr, waddr, wdata);
    end
    send(3'd4, 16'h5000, 16'h0, 16'h8007, 1'b0, 3, t);
    send(3'd0, 16'h1234, 16'h0, 16'h0000, 1'b0, 3, t);
    send(3'd3, 16'h8010, 16'h5000, 16'h5001, 1'b0, 3, t);
    checks++;
    if (alloc !== 1'b1 || free !== 1'b1 || faddr !== 16'h5000 || data !== 16'h8010) begin
      errors++;
      $display("FAIL realloc_strobe alloc=%b free=%b faddr=%h data=%h required 1/1/5000/8010",
               alloc, free, faddr, data);
    end
    drain();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL write_read_drain pending=%0d required=0", sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    send(3'd4, 16'h5001, 16'h0, 16'h8010, 1'b0, 3, t1);
    send(3'd4, 16'h5000, 16'h0, 16'h0BAD, 1'b0, 3, t2);
    checks++;
    if (t2 - t1 != 3) begin
      errors++;
      $display("FAIL back_to_back spacing=%0d required=3", t2 - t1);
    end
    drain();
  endtask

  task automatic test_free_list();
    int t, r0, f0;
    do_reset(1'b0);
    send(3'd1, 16'h0001, 16'h0, 16'h5000, 1'b0, 3, t);
    send(3'd1, 16'h5000, 16'h0, 16'h5001, 1'b0, 3, t);
    send(3'd1, 16'h5001, 16'h0, 16'h5002, 1'b0, 3, t);
    drain();
    r0 = n_rd;
    f0 = n_free;
    send(3'd6, 16'h5002, 16'h0, 16'h8003, 1'b0, 10, t);
    drain();
    checks++;
    if (n_rd - r0 != 3 || n_free - f0 != 3) begin
      errors++;
      $display("FAIL walk_strobes rd=%0d free=%0d required 3/3", n_rd - r0, n_free - f0);
    end
    send(3'd1, 16'h8000, 16'h0, 16'h5000, 1'b0, 3, t);
    send(3'd1, 16'h8000, 16'h0, 16'h5001, 1'b0, 3, t);
    send(3'd1, 16'h8000, 16'h0, 16'h5002, 1'b0, 3, t);
    drain();
    r0 = n_rd;
    f0 = n_free;
    send(3'd6, 16'h0001, 16'h0, 16'h8000, 1'b0, 3, t);
    drain();
    checks++;
    if (n_rd - r0 != 0 || n_free - f0 != 0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL walk_nil rd=%0d free=%0d pending=%0d required 0/0/0",
               n_rd - r0, n_free - f0, sbq.size());
    end
  endtask

  task automatic test_malformed();
    int t, a0, f0, r0, w0;
    do_reset(1'b0);
    send(3'd1, 16'h8009, 16'h0, 16'h5000, 1'b0, 3, t);
    drain();
    f0 = n_free;
    send(3'd6, 16'h5000, 16'h0, 16'h8001, 1'b1, 4, t);
    drain();
    checks++;
    if (n_free - f0 != 1) begin
      errors++;
      $display("FAIL malformed_frees got=%0d required=1", n_free - f0);
    end
    a0 = n_alloc; f0 = n_free; r0 = n_rd; w0 = n_wr;
    send(3'd7, 16'h5000, 16'h5000, 16'h0000, 1'b1, 3, t);
    drain();
    checks++;
    if (n_alloc != a0 || n_free != f0 || n_rd != r0 || n_wr != w0) begin
      errors++;
      $display("FAIL illegal_strobes alloc=%0d free=%0d rd=%0d wr=%0d required 0 each",
               n_alloc - a0, n_free - f0, n_rd - r0, n_wr - w0);
    end
    send(3'd1, 16'h1234, 16'h0, 16'h5000, 1'b0, 3, t);
    send(3'd2, 16'h5000, 16'h0, 16'h0000, 1'b0, 3, t);
    checks++;
    if (free !== 1'b1 || faddr !== 16'h5000 || alloc !== 1'b0) begin
      errors++;
      $display("FAIL free_strobe free=%b faddr=%h alloc=%b required 1/5000/0", free, faddr, alloc);
    end
    drain();
  endtask

  task automatic test_error();
    int t;
    do_reset(1'b0);
    send(3'd1, 16'h8005, 16'h0, 16'h0000, 1'b1, 2, t);
    alloc_err = 1'b1;
    repeat (2) @(negedge clk);
    alloc_err = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1 || cmd_ready !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL error_sticky o_err=%b ready=%b pending=%0d required 1/0/0",
               err, cmd_ready, sbq.size());
    end
    do_reset(1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL error_cleared o_err=%b required=0", err);
    end
  endtask

  task automatic test_reset_mid_walk();
    int t;
    send(3'd1, 16'h0001, 16'h0, 16'h5000, 1'b0, 3, t);
    send(3'd1, 16'h5000, 16'h0, 16'h5001, 1'b0, 3, t);
    drain();
    send(3'd6, 16'h5001, 16'h0, 16'h8002, 1'b0, 7, t);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sbq.delete();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, alloc, free, wr, rd, err,
         rsp_data, data, faddr, wdata, waddr, raddr} !== '0) begin
      errors++;
      $display("FAIL reset_mid_walk ready=%b rsp=%b free=%b rd=%b faddr=%h raddr=%h required all 0",
               cmd_ready, rsp_valid, free, rd, faddr, raddr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_write_read();
    test_back_to_back();
    test_free_list();
    test_malformed();
    test_error();
    test_reset_mid_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
